// File: rtl/pipe_scoreboard_if.sv
// Issue request and write-back schedule bundle between the ID stage and the
// register scoreboard; the ID stage is the master, the scoreboard the slave.
interface pipe_scoreboard_if #(
  parameter int AW = 5,
  parameter int LW = 4
);
  logic          issueValid;
  logic [AW-1:0] issueRs;
  logic [AW-1:0] issueRt;
  logic          issueUseRs;
  logic          issueUseRt;
  logic          issueWr;
  logic [AW-1:0] issueRd;
  logic [LW-1:0] issueLat;
  logic          flush;
  logic          stall;
  logic [1:0]    stallCause;
  logic          wbValid;
  logic [AW-1:0] wbRd;
  logic [LW-1:0] pending;

  modport master (
    output issueValid, issueRs, issueRt, issueUseRs, issueUseRt,
           issueWr, issueRd, issueLat, flush,
    input  stall, stallCause, wbValid, wbRd, pending
  );

  modport slave (
    input  issueValid, issueRs, issueRt, issueUseRs, issueUseRt,
           issueWr, issueRd, issueLat, flush,
    output stall, stallCause, wbValid, wbRd, pending
  );
endinterface

// File: rtl/pipe_scoreboard.sv
// Per-register latency scoreboard for the ID stage: raises RAW/WAW/structural
// issue stalls and keeps an ordered one-write-per-cycle write-back schedule.
module pipe_scoreboard #(
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int MAX_LAT = 8,
  parameter int LW      = 4
) (
  input logic              clk,
  input logic              rst,
  pipe_scoreboard_if.slave sb
);

  typedef enum logic [1:0] {
    CauseNone   = 2'd0,
    CauseRaw    = 2'd1,
    CauseWaw    = 2'd2,
    CauseStruct = 2'd3
  } stallCauseT;

  localparam logic [LW-1:0] maxLat = LW'(MAX_LAT);
  localparam logic [LW-1:0] one    = LW'(1);

  logic [LW-1:0] cnt          [NREG];
  logic [LW-1:0] cntNext      [NREG];
  logic          slotValid    [1:MAX_LAT];
  logic          slotValidNext[1:MAX_LAT];
  logic [AW-1:0] slotRd       [1:MAX_LAT];
  logic [AW-1:0] slotRdNext   [1:MAX_LAT];
  logic [LW-1:0] pendingQ;
  logic [LW-1:0] pendingNext;

  logic       tracked;
  logic       rawHit;
  logic       wawHit;
  logic       structHit;
  logic       accept;
  logic       load;
  stallCauseT cause;

  // Hazard detection: a counter of 1 means the value is bypassable this cycle,
  // and a new result may only land in a write-back slot nobody else owns.
  always_comb begin
    tracked   = sb.issueWr && (sb.issueRd != '0);
    rawHit    = (sb.issueUseRs && (sb.issueRs != '0) && (cnt[sb.issueRs] > one)) ||
                (sb.issueUseRt && (sb.issueRt != '0) && (cnt[sb.issueRt] > one));
    wawHit    = tracked && (cnt[sb.issueRd] > sb.issueLat);
    structHit = (sb.issueLat == '0) || (sb.issueLat > maxLat);
    for (int k = 2; k <= MAX_LAT; k++) begin
      if (tracked && slotValid[k] && ((sb.issueLat + one) == LW'(k))) begin
        structHit = 1'b1;
      end
    end
    cause = CauseNone;
    if (sb.issueValid) begin
      if (rawHit) begin
        cause = CauseRaw;
      end else if (wawHit) begin
        cause = CauseWaw;
      end else if (structHit) begin
        cause = CauseStruct;
      end
    end
    accept = sb.issueValid && (cause == CauseNone) && !sb.flush;
    load   = accept && tracked;
  end

  // Next state: everything ages by one cycle, then a tracked issue claims its
  // counter and slot; flush overrides both so a same-cycle issue is dropped.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cntNext[r] = (cnt[r] != '0) ? (cnt[r] - one) : '0;
    end
    if (load) begin
      cntNext[sb.issueRd] = sb.issueLat;
    end
    for (int k = 1; k < MAX_LAT; k++) begin
      slotValidNext[k] = slotValid[k+1];
      slotRdNext[k]    = slotRd[k+1];
    end
    slotValidNext[MAX_LAT] = 1'b0;
    slotRdNext[MAX_LAT]    = '0;
    if (load) begin
      for (int k = 1; k <= MAX_LAT; k++) begin
        if (LW'(k) == sb.issueLat) begin
          slotValidNext[k] = 1'b1;
          slotRdNext[k]    = sb.issueRd;
        end
      end
    end
    if (sb.flush) begin
      for (int r = 0; r < NREG; r++) begin
        cntNext[r] = '0;
      end
      for (int k = 1; k <= MAX_LAT; k++) begin
        slotValidNext[k] = 1'b0;
        slotRdNext[k]    = '0;
      end
    end
    pendingNext = '0;
    for (int k = 1; k <= MAX_LAT; k++) begin
      if (slotValidNext[k]) begin
        pendingNext = pendingNext + one;
      end
    end
  end

  // State registers; reset drops every in-flight entry immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
      for (int k = 1; k <= MAX_LAT; k++) begin
        slotValid[k] <= 1'b0;
        slotRd[k]    <= '0;
      end
      pendingQ <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= cntNext[r];
      end
      for (int k = 1; k <= MAX_LAT; k++) begin
        slotValid[k] <= slotValidNext[k];
        slotRd[k]    <= slotRdNext[k];
      end
      pendingQ <= pendingNext;
    end
  end

  assign sb.stall      = (cause != CauseNone);
  assign sb.stallCause = cause;
  assign sb.wbValid    = slotValid[1];
  assign sb.wbRd       = slotRd[1];
  assign sb.pending    = pendingQ;

endmodule
